// File: rtl/rv32_fetch_pkg.sv
// rv32_fetch_pkg: shared types and constants for the instruction-fetch stage.
package rv32_fetch_pkg;
    typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [3:0] RV32_MCAUSE_INSTR_MISALIGNED = 4'd0;
    localparam logic [3:0] RV32_MCAUSE_INSTR_FAULT_EXCEPTION = 4'd1;
endpackage

// File: rtl/rv32_fetch_if.sv
// rv32_fetch_if: instruction-bus signals between the fetch stage and memory.
interface rv32_fetch_if;
    logic [31:0] instr_address;
    logic        instr_read;
    logic [31:0] instr_read_value;
    logic        instr_ready;
    logic        instr_fault;
    modport master(output instr_address, instr_read, input instr_read_value, instr_ready, instr_fault);
    modport slave(input instr_address, instr_read, output instr_read_value, instr_ready, instr_fault);
endinterface

// File: rtl/rv32_fetch_predictor.sv
// rv32_fetch_predictor: static BTFN prediction; JAL and backward branches are taken.
module rv32_fetch_predictor
    import rv32_fetch_pkg::*;
#(
    parameter bit PREDICT = 1'b1
) (
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    output logic        taken,
    output logic [31:0] target
);
    logic [31:0] j_imm, b_imm;
    logic        is_jal, is_bwd;
    always_comb begin
        j_imm  = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
        b_imm  = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
        is_jal = instr[6:0] == OP_JAL;
        is_bwd = instr[6:0] == OP_BRANCH && instr[31];
        taken  = PREDICT && (is_jal || is_bwd);
        target = pc + (is_jal ? j_imm : b_imm);
    end
endmodule

// File: rtl/rv32_fetch.sv
// rv32_fetch: owns the PC, issues instruction reads, and feeds the fetch->decode registers.
module rv32_fetch
    import rv32_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter bit          PREDICT      = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_in,
    input  logic        flush_in,
    input  logic        redirect_in,
    input  logic [31:0] redirect_pc_in,
    rv32_fetch_if.master bus,
    output logic        fetch_wait_out,
    output logic        valid_out,
    output logic        exception_out,
    output logic [3:0]  exception_cause_out,
    output logic        branch_predicted_taken_out,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out
);
    state_t      state, state_next;
    logic [31:0] pc, next_pc, skid_instr, word, target;
    logic [31:2] drain_addr;
    logic        skid_fault, aligned, misaligned, bus_hit, deliver, fault, exc, taken, pred, advance, req;

    rv32_fetch_predictor #(.PREDICT(PREDICT)) u_pred (.instr(word), .pc(pc), .taken(taken), .target(target));

    assign bus.instr_read    = req;
    assign bus.instr_address = {state == DRAIN ? drain_addr : pc[31:2], 2'b00};

    always_comb begin
        aligned        = pc[1:0] == 2'b00;
        misaligned     = state == FETCH && !aligned;
        req            = (state == FETCH && aligned) || state == DRAIN;
        bus_hit        = state == FETCH && aligned && bus.instr_ready;
        deliver        = bus_hit || misaligned || state == HOLD;
        word           = state == HOLD ? skid_instr : bus.instr_read_value;
        fault          = state == HOLD ? skid_fault : bus.instr_fault;
        exc            = misaligned || fault;
        pred           = taken && !exc;
        next_pc        = pred ? target : pc + 32'd4;
        advance        = !stall_in && (bus_hit || state == HOLD);
        fetch_wait_out = !deliver;
        // A redirect with a request still in flight must wait out the old response.
        state_next     = redirect_in ? (req && !bus.instr_ready ? DRAIN : FETCH)
                       : state == FETCH ? (bus_hit && stall_in ? HOLD : FETCH)
                       : state == HOLD ? (stall_in ? HOLD : FETCH)
                       : (bus.instr_ready ? FETCH : DRAIN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state                      <= FETCH;
            pc                         <= RESET_VECTOR;
            drain_addr                 <= '0;
            skid_instr                 <= '0;
            skid_fault                 <= 1'b0;
            valid_out                  <= 1'b0;
            exception_out              <= 1'b0;
            exception_cause_out        <= '0;
            branch_predicted_taken_out <= 1'b0;
            pc_out                     <= '0;
            instr_out                  <= NOP;
        end else begin
            state <= state_next;
            if (state == FETCH) drain_addr <= pc[31:2];
            if (redirect_in) begin
                pc         <= redirect_pc_in;
                skid_instr <= '0;
                skid_fault <= 1'b0;
            end else begin
                if (advance) pc <= next_pc;
                if (bus_hit && stall_in) begin
                    skid_instr <= bus.instr_read_value;
                    skid_fault <= bus.instr_fault;
                end
            end
            if (redirect_in || (!stall_in && (flush_in || !deliver))) begin
                valid_out                  <= 1'b0;
                exception_out              <= 1'b0;
                branch_predicted_taken_out <= 1'b0;
            end else if (!stall_in) begin
                valid_out                  <= !exc;
                exception_out              <= exc;
                exception_cause_out        <= exc && !misaligned ? RV32_MCAUSE_INSTR_FAULT_EXCEPTION
                                                                  : RV32_MCAUSE_INSTR_MISALIGNED;
                branch_predicted_taken_out <= pred;
                pc_out                     <= pc;
                instr_out                  <= exc ? NOP : word;
            end
        end
    end
endmodule
